// File: rtl/dcache_pkg.sv
// Shared types and field widths for the direct-mapped write-back data cache.
package dcache_pkg;

    localparam int LINE_W  = 128;
    localparam int WORD_W  = 32;
    localparam int LADDR_W = 10;
    localparam int OFF_W   = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    function automatic int idx_w(input int n);
        return $clog2(n);
    endfunction

    function automatic int tag_w(input int n);
        return LADDR_W - $clog2(n);
    endfunction

    function automatic int off_w();
        return OFF_W;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid/dirty/tag/data storage: combinational read, word or full-line write.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int IDX_W     = 3,
    parameter int TAG_W     = 7
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [IDX_W-1:0]  i_idx,
    output logic              o_valid,
    output logic              o_dirty,
    output logic [TAG_W-1:0]  o_tag,
    output logic [LINE_W-1:0] o_line,
    input  logic              i_word_we,
    input  logic [1:0]        i_word_sel,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_fill_we,
    input  logic [LINE_W-1:0] i_fill_line,
    input  logic [TAG_W-1:0]  i_fill_tag,
    input  logic              i_clr_dirty
);

    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;
    logic [TAG_W-1:0]     r_tag  [NUM_LINES];
    logic [LINE_W-1:0]    r_data [NUM_LINES];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_fill_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= 1'b0;
        end else if (i_word_we) begin
            r_dirty[i_idx] <= 1'b1;
        end else if (i_clr_dirty) begin
            r_dirty[i_idx] <= 1'b0;
        end
    end

    // Tag and data contents are meaningless until valid is set, so no reset.
    always_ff @(posedge i_clk) begin
        if (i_fill_we) begin
            r_data[i_idx] <= i_fill_line;
            r_tag[i_idx]  <= i_fill_tag;
        end else if (i_word_we) begin
            r_data[i_idx][{i_word_sel, 5'b0} +: WORD_W] <= i_word;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate D-cache controller: hit path,
// miss FSM with registered DRAM drive and a saturating miss counter.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int MEM_LAT   = 6,
    parameter int ADDR_W    = 14
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               CPU_REQ,
    input  logic               CPU_WE,
    input  logic [ADDR_W-1:0]  CPU_ADDR,
    input  logic [WORD_W-1:0]  CPU_WDATA,
    output logic [WORD_W-1:0]  CPU_RDATA,
    output logic               CPU_STALL,
    output logic               D_MEM_CSN,
    output logic               D_MEM_WEN,
    output logic [LADDR_W-1:0] D_MEM_ADDR,
    output logic [LINE_W-1:0]  D_MEM_DOUT,
    input  logic [LINE_W-1:0]  D_MEM_DI,
    output logic [15:0]        MISS_CNT
);

    localparam int IDX_W = idx_w(NUM_LINES);
    localparam int TAG_W = tag_w(NUM_LINES);
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_e               r_state;
    logic [3:0]           r_cnt;
    logic                 r_csn;
    logic                 r_wen;
    logic [LADDR_W-1:0]   r_addr;
    logic [LINE_W-1:0]    r_dout;
    logic [15:0]          r_miss;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [1:0]           w_word;
    logic                 w_valid;
    logic                 w_dirty;
    logic [TAG_W-1:0]     w_rtag;
    logic [LINE_W-1:0]    w_line;
    logic                 w_idle;
    logic                 w_hit;
    logic                 w_miss;
    logic                 w_store;
    logic                 w_fill;
    logic                 w_wb_done;
    logic                 w_unused;

    assign w_idx    = CPU_ADDR[OFF_W +: IDX_W];
    assign w_tag    = CPU_ADDR[ADDR_W-1 -: TAG_W];
    assign w_word   = CPU_ADDR[3:2];
    assign w_unused = ^CPU_ADDR[1:0];

    assign w_idle    = (r_state == IDLE);
    assign w_hit     = CPU_REQ & w_valid & (w_rtag == w_tag);
    assign w_miss    = w_idle & CPU_REQ & ~w_hit;
    assign w_store   = w_idle & w_hit & CPU_WE;
    assign w_fill    = (r_state == ALLOCATE) & (r_cnt == '0);
    assign w_wb_done = (r_state == WRITEBACK) & ~r_csn;

    // Gated by RSTn so the pipeline is released the moment reset asserts.
    assign CPU_STALL = RSTn & (~w_idle | w_miss);
    assign CPU_RDATA = (w_idle & w_hit & ~CPU_WE)
                     ? w_line[{w_word, 5'b0} +: WORD_W] : '0;

    assign D_MEM_CSN  = r_csn;
    assign D_MEM_WEN  = r_wen;
    assign D_MEM_ADDR = r_addr;
    assign D_MEM_DOUT = r_dout;
    assign MISS_CNT   = r_miss;

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .i_clk       (CLK),
        .i_rst_n     (RSTn),
        .i_idx       (w_idx),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_rtag),
        .o_line      (w_line),
        .i_word_we   (w_store),
        .i_word_sel  (w_word),
        .i_word      (CPU_WDATA),
        .i_fill_we   (w_fill),
        .i_fill_line (D_MEM_DI),
        .i_fill_tag  (w_tag),
        .i_clr_dirty (w_wb_done & (r_cnt == '0))
    );

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_csn   <= 1'b1;
            r_wen   <= 1'b1;
            r_addr  <= '0;
            r_dout  <= '0;
            r_miss  <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_miss) begin
                        if (r_miss != 16'hFFFF) r_miss <= r_miss + 16'd1;
                        r_cnt <= LAT_INIT;
                        r_csn <= 1'b0;
                        if (w_valid & w_dirty) begin
                            r_state <= WRITEBACK;
                            r_wen   <= 1'b0;
                            r_addr  <= {w_rtag, w_idx};
                            r_dout  <= w_line;
                        end else begin
                            r_state <= ALLOCATE;
                            r_wen   <= 1'b1;
                            r_addr  <= CPU_ADDR[ADDR_W-1:OFF_W];
                        end
                    end
                end
                WRITEBACK: begin
                    // CSN high for one gap cycle before the fill starts.
                    if (!r_csn) begin
                        if (r_cnt == '0) begin
                            r_csn <= 1'b1;
                            r_wen <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 4'd1;
                        end
                    end else begin
                        r_state <= ALLOCATE;
                        r_csn   <= 1'b0;
                        r_wen   <= 1'b1;
                        r_addr  <= CPU_ADDR[ADDR_W-1:OFF_W];
                        r_cnt   <= LAT_INIT;
                    end
                end
                ALLOCATE: begin
                    if (r_cnt == '0) begin
                        r_state <= IDLE;
                        r_csn   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed + random bench: flat-memory reference with a tag-level miss model.
module tb_dcache_ctrl;

    localparam int NL  = 8;
    localparam int LAT = 6;

    logic         CLK;
    logic         RSTn;
    logic         CPU_REQ;
    logic         CPU_WE;
    logic [13:0]  CPU_ADDR;
    logic [31:0]  CPU_WDATA;
    logic [31:0]  CPU_RDATA;
    logic         CPU_STALL;
    logic         D_MEM_CSN;
    logic         D_MEM_WEN;
    logic [9:0]   D_MEM_ADDR;
    logic [127:0] D_MEM_DOUT;
    logic [127:0] w_di;
    logic [15:0]  MISS_CNT;

    dcache_ctrl #(
        .NUM_LINES (NL),
        .MEM_LAT   (LAT),
        .ADDR_W    (14)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .CPU_REQ    (CPU_REQ),
        .CPU_WE     (CPU_WE),
        .CPU_ADDR   (CPU_ADDR),
        .CPU_WDATA  (CPU_WDATA),
        .CPU_RDATA  (CPU_RDATA),
        .CPU_STALL  (CPU_STALL),
        .D_MEM_CSN  (D_MEM_CSN),
        .D_MEM_WEN  (D_MEM_WEN),
        .D_MEM_ADDR (D_MEM_ADDR),
        .D_MEM_DOUT (D_MEM_DOUT),
        .D_MEM_DI   (w_di),
        .MISS_CNT   (MISS_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [9:0]   addr;
        logic         wen;
        int           len;
        logic [127:0] dout;
    } tx_t;

    logic [127:0] dram    [1024];
    logic [127:0] ref_mem [1024];
    tx_t          txq[$];
    int           glitch;
    logic         mon_prev;

    bit           mv_valid [NL];
    bit           mv_dirty [NL];
    int           mv_tag   [NL];
    int           exp_miss;

    int vectors;
    int miscompares;

    assign w_di = dram[D_MEM_ADDR];

    // DRAM model and bus monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RSTn) begin
            mon_prev = 1'b1;
        end else begin
            if (!D_MEM_CSN) begin
                if (mon_prev) begin
                    txq.push_back('{D_MEM_ADDR, D_MEM_WEN, 1, D_MEM_DOUT});
                end else begin
                    if (txq[txq.size()-1].addr != D_MEM_ADDR ||
                        txq[txq.size()-1].wen != D_MEM_WEN ||
                        txq[txq.size()-1].dout != D_MEM_DOUT)
                        glitch++;
                    txq[txq.size()-1].len++;
                end
                if (!D_MEM_WEN) dram[D_MEM_ADDR] = D_MEM_DOUT;
            end
            mon_prev = D_MEM_CSN;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            mv_valid[i] = 0;
            mv_dirty[i] = 0;
        end
        exp_miss = 0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = dram[i];
    endtask

    task automatic op(input logic we, input logic [13:0] a,
                      input logic [31:0] wd);
        int idx, tg, ln, w, stalls, nexp, exp_stall, victim;
        bit hit, dev;
        idx = int'(a[6:4]);
        tg  = int'(a[13:7]);
        ln  = int'(a[13:4]);
        w   = int'(a[3:2]);
        hit = mv_valid[idx] && mv_tag[idx] == tg;
        dev = !hit && mv_valid[idx] && mv_dirty[idx];
        victim = mv_tag[idx] * NL + idx;
        exp_stall = hit ? 0 : (dev ? 2 + 2 * LAT : 1 + LAT);
        nexp = hit ? 0 : (dev ? 2 : 1);
        txq.delete();
        glitch = 0;
        CPU_REQ = 1'b1;
        CPU_WE = we;
        CPU_ADDR = a;
        CPU_WDATA = wd;
        stalls = 0;
        forever begin
            @(negedge CLK);
            if (!CPU_STALL) break;
            stalls++;
            if (stalls > 100) begin
                chk("stall_timeout", 128'(stalls), 128'(exp_stall));
                break;
            end
            @(posedge CLK);
            #1;
        end
        if (!we) chk("rdata", 128'(CPU_RDATA), 128'(ref_mem[ln][w*32 +: 32]));
        @(posedge CLK);
        #1;
        CPU_REQ = 1'b0;
        if (!hit) begin
            if (exp_miss < 65535) exp_miss++;
            mv_valid[idx] = 1;
            mv_tag[idx] = tg;
            mv_dirty[idx] = 0;
        end
        if (we) begin
            ref_mem[ln][w*32 +: 32] = wd;
            mv_dirty[idx] = 1;
        end
        chk("stall_cycles", 128'(stalls), 128'(exp_stall));
        chk("miss_cnt", 128'(MISS_CNT), 128'(exp_miss));
        chk("num_tx", 128'(txq.size()), 128'(nexp));
        chk("glitch", 128'(glitch), 128'(0));
        if (!hit && txq.size() == nexp) begin
            if (dev) begin
                chk("wb_addr", 128'(txq[0].addr), 128'(victim));
                chk("wb_wen", 128'(txq[0].wen), 128'(0));
                chk("wb_len", 128'(txq[0].len), 128'(LAT));
                chk("wb_line", txq[0].dout, ref_mem[victim]);
            end
            chk("fill_addr", 128'(txq[nexp-1].addr), 128'(ln));
            chk("fill_wen", 128'(txq[nexp-1].wen), 128'(1));
            chk("fill_len", 128'(txq[nexp-1].len), 128'(LAT));
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        glitch = 0;
        mon_prev = 1'b1;
        for (int i = 0; i < 1024; i++)
            dram[i] = {$urandom, $urandom, $urandom, $urandom};
        dram[10'h010][31:0]   = 32'h11111111;
        dram[10'h3FF][127:96] = 32'hCAFEF00D;
        model_reset();
        RSTn = 1'b0;
        CPU_REQ = 1'b0;
        CPU_WE = 1'b0;
        CPU_ADDR = '0;
        CPU_WDATA = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_csn", 128'(D_MEM_CSN), 128'(1));
        chk("rst_wen", 128'(D_MEM_WEN), 128'(1));
        chk("rst_addr", 128'(D_MEM_ADDR), 128'(0));
        chk("rst_dout", D_MEM_DOUT, 128'(0));
        chk("rst_miss", 128'(MISS_CNT), 128'(0));
        chk("rst_stall", 128'(CPU_STALL), 128'(0));
        chk("rst_rdata", 128'(CPU_RDATA), 128'(0));
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;

        op(1'b0, 14'h0100, 32'h0);
        chk("t1_word0", 128'(ref_mem[10'h010][31:0]), 128'(32'h11111111));
        op(1'b1, 14'h0104, 32'hDEADBEEF);
        op(1'b0, 14'h0104, 32'h0);
        op(1'b0, 14'h0180, 32'h0);
        chk("t3_dram", dram[10'h010][63:32], 128'(32'hDEADBEEF));
        op(1'b1, 14'h0208, 32'hA5A55A5A);
        op(1'b0, 14'h0288, 32'h0);
        chk("t4_dram", dram[10'h020][95:64], 128'(32'hA5A55A5A));
        op(1'b0, 14'h3FFC, 32'h0);

        CPU_REQ = 1'b1;
        CPU_WE = 1'b0;
        CPU_ADDR = 14'h0100;
        repeat (3) @(posedge CLK);
        #1;
        RSTn = 1'b0;
        #1;
        chk("t6_csn", 128'(D_MEM_CSN), 128'(1));
        chk("t6_stall", 128'(CPU_STALL), 128'(0));
        chk("t6_miss", 128'(MISS_CNT), 128'(0));
        CPU_REQ = 1'b0;
        model_reset();
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        op(1'b0, 14'h0100, 32'h0);

        for (int n = 0; n < 150; n++) begin
            logic [13:0] a;
            a = {7'($urandom_range(0, 3) * 29), 3'($urandom),
                 2'($urandom), 2'($urandom)};
            op(1'($urandom), a, $urandom);
            repeat ($urandom_range(0, 2)) begin
                @(posedge CLK);
                #1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
